// File: rtl/icap_reg_reader_if.sv
// Request/response handshake plus the ICAP_SPARTAN3A pin bundle for icap_reg_reader.
// The slave modport is the reader; the master modport is its requester and the ICAP side.
interface icap_reg_reader_if;
  logic        start;
  logic [5:0]  reg_addr;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] rd_data;
  logic        icap_clk;
  logic        icap_ce;
  logic        icap_write;
  logic [7:0]  icap_i;
  logic [7:0]  icap_o;
  logic        icap_busy;

  modport master (
    output start, reg_addr, icap_o, icap_busy,
    input  busy, done, err, rd_data, icap_clk, icap_ce, icap_write, icap_i
  );

  modport slave (
    input  start, reg_addr, icap_o, icap_busy,
    output busy, done, err, rd_data, icap_clk, icap_ce, icap_write, icap_i
  );
endinterface

// File: rtl/icap_reg_reader.sv
// Reads one 16-bit configuration register through the Spartan-3A ICAP: sync + read header,
// data capture with busy/timeout handling, then desync. ICAP clock is bit-banged in 3 phases.
module icap_reg_reader #(
  parameter int RD_DUMMY     = 2,
  parameter int BUSY_TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst,
  icap_reg_reader_if.slave bus
);

  typedef enum logic [2:0] {IDLE, WR_HDR, SW_RD, RD, SW_WR, WR_DESYNC, FIN} state_t;

  localparam logic [3:0] DUMMY_N  = 4'(RD_DUMMY);
  localparam logic [7:0] BUSY_LIM = 8'(BUSY_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [1:0]  phase;
  logic [3:0]  slot, slot_nxt;
  logic [7:0]  busy_cnt, busy_cnt_nxt;
  logic [5:0]  addr_r;
  logic        icap_clk_r, icap_ce_r, icap_write_r;
  logic [7:0]  icap_i_r;
  logic        done_r, err_r;
  logic [15:0] rd_data_r;
  logic        slot_end, accept, cap_hi, cap_lo, tmo;
  logic        drv_ce, drv_write;
  logic [7:0]  drv_byte;

  // ICAP data pins are bit-reversed relative to the configuration byte order.
  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [7:0] hdr_byte(input logic [3:0] idx, input logic [5:0] addr);
    logic [15:0] hw;
    hw = {3'b001, 2'b01, addr, 5'b00001};
    case (idx)
      4'd0:    return 8'hAA;
      4'd1:    return 8'h99;
      4'd4:    return hw[15:8];
      4'd5:    return hw[7:0];
      4'd2, 4'd6, 4'd8: return 8'h20;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] desync_byte(input logic [3:0] idx);
    case (idx)
      4'd0:       return 8'h30;
      4'd1:       return 8'hA1;
      4'd3:       return 8'h0D;
      4'd4, 4'd6: return 8'h20;
      default:    return 8'h00;
    endcase
  endfunction

  assign slot_end = (phase == 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      phase    <= 2'd0;
      slot     <= 4'd0;
      busy_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      slot     <= slot_nxt;
      busy_cnt <= busy_cnt_nxt;
      phase    <= (state == IDLE || state == FIN || slot_end) ? 2'd0 : phase + 2'd1;
    end
  end

  always_comb begin
    state_nxt    = state;
    slot_nxt     = slot;
    busy_cnt_nxt = busy_cnt;
    accept       = 1'b0;
    cap_hi       = 1'b0;
    cap_lo       = 1'b0;
    tmo          = 1'b0;
    drv_ce       = 1'b1;
    drv_write    = 1'b1;
    drv_byte     = 8'h00;
    case (state)
      IDLE: begin
        // done_r blocks a start that coincides with the completion pulse
        if (bus.start && !done_r) begin
          accept       = 1'b1;
          state_nxt    = WR_HDR;
          slot_nxt     = 4'd0;
          busy_cnt_nxt = 8'd0;
        end
      end
      WR_HDR: begin
        drv_ce    = 1'b0;
        drv_write = 1'b0;
        drv_byte  = hdr_byte(slot, addr_r);
        if (slot_end) begin
          if (slot == 4'd9) begin
            state_nxt = SW_RD;
            slot_nxt  = 4'd0;
          end else begin
            slot_nxt = slot + 4'd1;
          end
        end
      end
      SW_RD: begin
        if (slot_end) begin
          state_nxt    = RD;
          slot_nxt     = 4'd0;
          busy_cnt_nxt = 8'd0;
        end
      end
      RD: begin
        drv_ce = 1'b0;
        if (slot_end) begin
          if (slot < DUMMY_N) begin
            slot_nxt = slot + 4'd1;
          end else if (bus.icap_busy) begin
            if (busy_cnt == BUSY_LIM) begin
              tmo       = 1'b1;
              state_nxt = SW_WR;
              slot_nxt  = 4'd0;
            end else begin
              busy_cnt_nxt = busy_cnt + 8'd1;
            end
          end else begin
            busy_cnt_nxt = 8'd0;
            if (slot == DUMMY_N) begin
              cap_hi   = 1'b1;
              slot_nxt = slot + 4'd1;
            end else begin
              cap_lo    = 1'b1;
              state_nxt = SW_WR;
              slot_nxt  = 4'd0;
            end
          end
        end
      end
      SW_WR: begin
        drv_write = 1'b0;
        if (slot_end) begin
          state_nxt = WR_DESYNC;
          slot_nxt  = 4'd0;
        end
      end
      WR_DESYNC: begin
        drv_ce    = 1'b0;
        drv_write = 1'b0;
        drv_byte  = desync_byte(slot);
        if (slot_end) begin
          if (slot == 4'd7) state_nxt = FIN;
          else              slot_nxt  = slot + 4'd1;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      icap_clk_r   <= 1'b0;
      icap_ce_r    <= 1'b1;
      icap_write_r <= 1'b1;
      icap_i_r     <= 8'h00;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      rd_data_r    <= 16'h0000;
    end else begin
      done_r <= (state == FIN);
      if (state == FIN) begin
        icap_ce_r    <= 1'b1;
        icap_write_r <= 1'b1;
        icap_i_r     <= 8'h00;
      end else if (state != IDLE) begin
        case (phase)
          2'd0: begin
            icap_i_r     <= rev8(drv_byte);
            icap_ce_r    <= drv_ce;
            icap_write_r <= drv_write;
          end
          2'd1:    icap_clk_r <= 1'b1;
          default: icap_clk_r <= 1'b0;
        endcase
      end
      if (accept) err_r <= 1'b0;
      if (tmo) begin
        err_r     <= 1'b1;
        rd_data_r <= 16'h0000;
      end
      if (cap_hi) rd_data_r[15:8] <= rev8(bus.icap_o);
      if (cap_lo) rd_data_r[7:0]  <= rev8(bus.icap_o);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) addr_r <= bus.reg_addr;
  end

  assign bus.busy       = (state != IDLE) || done_r;
  assign bus.done       = done_r;
  assign bus.err        = err_r;
  assign bus.rd_data    = rd_data_r;
  assign bus.icap_clk   = icap_clk_r;
  assign bus.icap_ce    = icap_ce_r;
  assign bus.icap_write = icap_write_r;
  assign bus.icap_i     = icap_i_r;

endmodule
